// File: rtl/dmem_sched_pkg.sv
// Shared constants, FSM state type and lane extraction helper for the
// data memory write scheduler.
package dmem_sched_pkg;

  localparam int LANES  = 5;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int STRIDE = 4;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [DW-1:0] lane_slice(input logic [LANES*DW-1:0] data,
                                               input logic [IDX_W-1:0]    idx);
    return data[int'(idx)*DW +: DW];
  endfunction

endpackage

// File: rtl/dmem_write_sched_if.sv
// Bus bundle between the core store outputs, the vector store requester and
// the data memory write port.
interface dmem_write_sched_if;
  import dmem_sched_pkg::*;

  logic                  s_we;
  logic [AW-1:0]         s_adr;
  logic [DW-1:0]         s_wdata;
  // v_req/v_ready: a vector store transfers on a rising edge where both are 1.
  // The requester holds v_req and the v_* payload stable until that edge;
  // v_req seen while v_ready=0 is ignored, and v_ready does not depend on v_req.
  logic                  v_req;
  logic                  v_ready;
  logic [AW-1:0]         v_base;
  logic [LANES-1:0]      v_mask;
  logic [LANES*DW-1:0]   v_data;
  logic                  v_done;
  logic                  busy;
  logic                  mem_we;
  logic [AW-1:0]         mem_adr;
  logic [DW-1:0]         mem_wdata;

  modport master (
    output s_we, s_adr, s_wdata, v_req, v_base, v_mask, v_data,
    input  v_ready, v_done, busy, mem_we, mem_adr, mem_wdata
  );

  modport slave (
    input  s_we, s_adr, s_wdata, v_req, v_base, v_mask, v_data,
    output v_ready, v_done, busy, mem_we, mem_adr, mem_wdata
  );

endinterface

// File: rtl/dmem_write_sched_lane_pick.sv
// Lowest-set-bit encoder: picks the next vector lane to retire.
module lane_pick
  import dmem_sched_pkg::*;
(
  input  logic [LANES-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dmem_write_sched.sv
// Single-port data memory write scheduler: scalar stores pass straight through,
// vector store lanes are drained into cycles the core leaves free.
module dmem_write_sched
  import dmem_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  dmem_write_sched_if.slave  bus,
  output state_e             dbg_state
);

  state_e                state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [LANES*DW-1:0]   data_q, data_d;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_any;
  logic                  lane_we;
  logic [AW-1:0]         lane_adr;
  logic [DW-1:0]         lane_wdata;

  lane_pick u_lane_pick (
    .mask (mask_q),
    .idx  (cur_idx),
    .any  (cur_any)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.v_req) begin
          base_d  = bus.v_base;
          mask_d  = bus.v_mask;
          data_d  = bus.v_data;
          state_d = (|bus.v_mask) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        // A scalar store owns the port this cycle; the pending lane waits.
        if (!bus.s_we) begin
          mask_d = mask_q & ~(LANES'(1) << cur_idx);
          if (mask_d == '0) state_d = DONE;
        end
        if (!cur_any) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  // Reset masks the vector side immediately so nothing stale reaches memory.
  assign lane_we    = (state_q == DRAIN) && cur_any && !reset;
  assign lane_adr   = base_q + (AW'(cur_idx) * AW'(STRIDE));
  assign lane_wdata = lane_slice(data_q, cur_idx);

  assign bus.v_ready   = reset || (state_q == IDLE);
  assign bus.busy      = !reset && (state_q == DRAIN);
  assign bus.v_done    = !reset && (state_q == DONE);

  assign bus.mem_we    = bus.s_we || lane_we;
  assign bus.mem_adr   = bus.s_we ? bus.s_adr   : lane_adr;
  assign bus.mem_wdata = bus.s_we ? bus.s_wdata : lane_wdata;

  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_write_sched.sv
// Bench for dmem_write_sched: directed cycle tables plus a randomized run
// against a lane-queue reference model.
module tb_dmem_write_sched;
  import dmem_sched_pkg::*;

  localparam int NC = 12;
  localparam logic [LANES*DW-1:0] DATA_1_5 = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

  logic   clk = 1'b0;
  logic   reset;
  state_e dbg_state;
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  dmem_write_sched_if bus ();

  dmem_write_sched dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Observation log filled by capture_vec, one entry per cycle.
  logic          obs_we    [NC];
  logic [AW-1:0] obs_adr   [NC];
  logic [DW-1:0] obs_data  [NC];
  logic          obs_done  [NC];
  logic          obs_ready [NC];
  logic          obs_busy  [NC];

  // Software ordering rule: no scalar store into the accepted vector's range while busy.
  logic [AW-1:0] acc_base = '0;
  always @(posedge clk) if (!reset && bus.v_ready && bus.v_req) acc_base <= bus.v_base;
  always @(negedge clk) begin
    if (bus.busy && bus.s_we)
      assert ((bus.s_adr - acc_base) >= AW'(LANES * STRIDE))
        else $error("scalar store overlaps pending vector range");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_wdata = '0;
    bus.v_req   = 1'b0;
  endtask

  task automatic load_vec(input logic [AW-1:0] base, input logic [LANES-1:0] mask,
                          input logic [LANES*DW-1:0] data);
    bus.v_base = base;
    bus.v_mask = mask;
    bus.v_data = data;
  endtask

  task automatic capture_vec(input logic [AW-1:0] base, input logic [LANES-1:0] mask,
                             input logic [LANES*DW-1:0] data, input int req_last,
                             input int coll_cyc, input logic [AW-1:0] coll_adr,
                             input logic [DW-1:0] coll_data, input int ncyc);
    load_vec(base, mask, data);
    for (int c = 0; c < ncyc; c++) begin
      bus.v_req   = (c <= req_last);
      bus.s_we    = (c == coll_cyc);
      bus.s_adr   = coll_adr;
      bus.s_wdata = coll_data;
      @(negedge clk);
      obs_we[c]    = bus.mem_we;
      obs_adr[c]   = bus.mem_adr;
      obs_data[c]  = bus.mem_wdata;
      obs_done[c]  = bus.v_done;
      obs_ready[c] = bus.v_ready;
      obs_busy[c]  = bus.busy;
      next_cycle();
    end
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    load_vec('0, '0, '0);
    bus.s_we = 1'b1; bus.s_adr = 32'h40; bus.s_wdata = 32'h55; bus.v_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rst_mem_we got=%0b want=1", bus.mem_we); end
    checks++; if (bus.mem_adr !== 32'h40) begin errors++; $display("FAIL rst_mem_adr got=%h want=40", bus.mem_adr); end
    checks++; if (bus.mem_wdata !== 32'h55) begin errors++; $display("FAIL rst_mem_wdata got=%h want=55", bus.mem_wdata); end
    checks++; if (bus.v_ready !== 1'b1) begin errors++; $display("FAIL rst_v_ready got=%0b want=1", bus.v_ready); end
    checks++; if (bus.busy !== 1'b0 || bus.v_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%0b%0b want=00", bus.busy, bus.v_done); end
    next_cycle();
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, IDLE); end
    checks++; if (bus.mem_we !== 1'b0 || bus.v_ready !== 1'b1) begin errors++; $display("FAIL post_rst we/ready got=%0b/%0b want=0/1", bus.mem_we, bus.v_ready); end
    next_cycle();
  endtask

  task automatic test_scalar();
    bus.s_we = 1'b1; bus.s_adr = 32'd100; bus.s_wdata = 32'd7;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL scalar_we got=%0b want=1", bus.mem_we); end
    checks++; if (bus.mem_adr !== 32'd100) begin errors++; $display("FAIL scalar_adr got=%0d want=100", bus.mem_adr); end
    checks++; if (bus.mem_wdata !== 32'd7) begin errors++; $display("FAIL scalar_wdata got=%0d want=7", bus.mem_wdata); end
    checks++; if (bus.v_ready !== 1'b1) begin errors++; $display("FAIL scalar_ready got=%0b want=1", bus.v_ready); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_full_vector();
    capture_vec(32'h200, 5'b11111, DATA_1_5, 0, -1, '0, '0, 8);
    checks++; if (obs_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready0 got=%0b want=1", obs_ready[0]); end
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (obs_we[c] !== 1'b1 || obs_adr[c] !== 32'h200 + 32'(4*(c-1)) || obs_data[c] !== 32'(c) || obs_busy[c] !== 1'b1) begin
        errors++;
        $display("FAIL full_lane[%0d] got we=%0b adr=%h data=%0d busy=%0b want we=1 adr=%h data=%0d busy=1",
                 c, obs_we[c], obs_adr[c], obs_data[c], obs_busy[c], 32'h200 + 32'(4*(c-1)), c);
      end
    end
    checks++; if (obs_done[5] !== 1'b0 || obs_done[6] !== 1'b1) begin errors++; $display("FAIL full_done c5/c6 got=%0b/%0b want=0/1", obs_done[5], obs_done[6]); end
    checks++; if (obs_we[6] !== 1'b0 || obs_ready[6] !== 1'b0) begin errors++; $display("FAIL full_c6 we/ready got=%0b/%0b want=0/0", obs_we[6], obs_ready[6]); end
    checks++; if (obs_ready[7] !== 1'b1 || obs_done[7] !== 1'b0) begin errors++; $display("FAIL full_c7 ready/done got=%0b/%0b want=1/0", obs_ready[7], obs_done[7]); end
  endtask

  task automatic test_collision();
    logic          w_we   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] w_adr  [9] = '{32'h0, 32'h200, 32'd96, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h0, 32'h0};
    logic [DW-1:0] w_dat  [9] = '{32'd0, 32'd1, 32'd9, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0};
    capture_vec(32'h200, 5'b11111, DATA_1_5, 0, 2, 32'd96, 32'd9, 9);
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (obs_we[c] !== w_we[c] || (w_we[c] && (obs_adr[c] !== w_adr[c] || obs_data[c] !== w_dat[c]))) begin
        errors++;
        $display("FAIL coll_c%0d got we=%0b adr=%h data=%0d want we=%0b adr=%h data=%0d",
                 c, obs_we[c], obs_adr[c], obs_data[c], w_we[c], w_adr[c], w_dat[c]);
      end
      checks++;
      if (obs_done[c] !== (c == 7)) begin errors++; $display("FAIL coll_done_c%0d got=%0b want=%0b", c, obs_done[c], c == 7); end
    end
  endtask

  task automatic test_sparse_empty();
    logic [AW-1:0] w_adr [3] = '{32'h200, 32'h208, 32'h210};
    logic [DW-1:0] w_dat [3] = '{32'd1, 32'd3, 32'd5};
    capture_vec(32'h200, 5'b10101, DATA_1_5, 0, -1, '0, '0, 6);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (obs_we[c] !== 1'b1 || obs_adr[c] !== w_adr[c-1] || obs_data[c] !== w_dat[c-1]) begin
        errors++;
        $display("FAIL sparse_c%0d got we=%0b adr=%h data=%0d want we=1 adr=%h data=%0d",
                 c, obs_we[c], obs_adr[c], obs_data[c], w_adr[c-1], w_dat[c-1]);
      end
    end
    checks++; if (obs_done[4] !== 1'b1 || obs_we[4] !== 1'b0) begin errors++; $display("FAIL sparse_done got done=%0b we=%0b want 1/0", obs_done[4], obs_we[4]); end
    capture_vec(32'h200, 5'b00000, DATA_1_5, 0, -1, '0, '0, 3);
    checks++; if (obs_we[0] !== 1'b0 || obs_we[1] !== 1'b0 || obs_we[2] !== 1'b0) begin errors++; $display("FAIL empty_we got=%0b%0b%0b want=000", obs_we[0], obs_we[1], obs_we[2]); end
    checks++; if (obs_done[1] !== 1'b1 || obs_ready[1] !== 1'b0) begin errors++; $display("FAIL empty_done got done=%0b ready=%0b want 1/0", obs_done[1], obs_ready[1]); end
    checks++; if (obs_ready[2] !== 1'b1 || obs_done[2] !== 1'b0) begin errors++; $display("FAIL empty_after got ready=%0b done=%0b want 1/0", obs_ready[2], obs_done[2]); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] w_adr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    capture_vec(32'hFFFF_FFF8, 5'b00111, DATA_1_5, 0, -1, '0, '0, 6);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (obs_we[c] !== 1'b1 || obs_adr[c] !== w_adr[c-1] || obs_data[c] !== 32'(c)) begin
        errors++;
        $display("FAIL wrap_c%0d got we=%0b adr=%h data=%0d want we=1 adr=%h data=%0d",
                 c, obs_we[c], obs_adr[c], obs_data[c], w_adr[c-1], c);
      end
    end
    checks++; if (obs_done[4] !== 1'b1 || obs_we[4] !== 1'b0) begin errors++; $display("FAIL wrap_done got done=%0b we=%0b want 1/0", obs_done[4], obs_we[4]); end
  endtask

  task automatic test_reset_mid_drain();
    load_vec(32'h200, 5'b11111, DATA_1_5);
    bus.v_req = 1'b1;
    next_cycle();
    bus.v_req = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h204) begin errors++; $display("FAIL rmd_lane2 got we=%0b adr=%h want 1/204", bus.mem_we, bus.mem_adr); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmd_rst_we got=%0b want=0", bus.mem_we); end
    checks++; if (bus.v_ready !== 1'b1 || bus.busy !== 1'b0 || bus.v_done !== 1'b0) begin errors++; $display("FAIL rmd_rst_flags got ready=%0b busy=%0b done=%0b want 1/0/0", bus.v_ready, bus.busy, bus.v_done); end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b0 || bus.v_done !== 1'b0 || bus.v_ready !== 1'b1 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL rmd_after_c%0d got we=%0b done=%0b ready=%0b state=%0d want 0/0/1/%0d",
                 c, bus.mem_we, bus.v_done, bus.v_ready, dbg_state, IDLE);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic          w_we    [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] w_adr   [9] = '{32'h0, 32'h300, 32'h304, 32'h0, 32'h0, 32'h300, 32'h304, 32'h0, 32'h0};
    logic          w_ready [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic          w_done  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    capture_vec(32'h300, 5'b00011, {32'd0, 32'd0, 32'd0, 32'hB2, 32'hA1}, 4, -1, '0, '0, 9);
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (obs_we[c] !== w_we[c] || (w_we[c] && obs_adr[c] !== w_adr[c]) ||
          obs_ready[c] !== w_ready[c] || obs_done[c] !== w_done[c]) begin
        errors++;
        $display("FAIL b2b_c%0d got we=%0b adr=%h ready=%0b done=%0b want we=%0b adr=%h ready=%0b done=%0b",
                 c, obs_we[c], obs_adr[c], obs_ready[c], obs_done[c], w_we[c], w_adr[c], w_ready[c], w_done[c]);
      end
    end
  endtask

  // Reference model: an accepted vector becomes a queue of {addr,data} lane
  // writes in ascending lane order; a free port cycle retires the head.
  task automatic test_random();
    logic [AW+DW-1:0] exp_q[$];
    int               phase = 0;  // 0 waiting, 1 lanes queued, 2 completion pulse
    logic             e_we, e_ready, e_busy, e_done;
    logic [AW-1:0]    e_adr;
    logic [DW-1:0]    e_dat;
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      bus.s_we    = ($urandom_range(0, 99) < 30);
      bus.s_adr   = 32'($urandom_range(0, 255));
      bus.s_wdata = $urandom;
      bus.v_req   = $urandom_range(0, 1) == 1;
      bus.v_base  = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
      bus.v_mask  = LANES'($urandom_range(0, 31));
      for (int i = 0; i < LANES; i++) bus.v_data[i*DW +: DW] = $urandom;
      @(negedge clk);
      e_ready = reset || phase == 0;
      e_busy  = !reset && phase == 1;
      e_done  = !reset && phase == 2;
      e_we    = bus.s_we || (!reset && phase == 1);
      e_adr   = bus.s_we ? bus.s_adr : (phase == 1 ? exp_q[0][AW+DW-1:DW] : '0);
      e_dat   = bus.s_we ? bus.s_wdata : (phase == 1 ? exp_q[0][DW-1:0] : '0);
      checks++;
      if (bus.v_ready !== e_ready || bus.busy !== e_busy || bus.v_done !== e_done) begin
        errors++;
        $display("FAIL rand_flags n=%0d got ready=%0b busy=%0b done=%0b want %0b/%0b/%0b",
                 n, bus.v_ready, bus.busy, bus.v_done, e_ready, e_busy, e_done);
      end
      checks++;
      if (bus.mem_we !== e_we || (e_we && (bus.mem_adr !== e_adr || bus.mem_wdata !== e_dat))) begin
        errors++;
        $display("FAIL rand_mem n=%0d got we=%0b adr=%h data=%h want we=%0b adr=%h data=%h",
                 n, bus.mem_we, bus.mem_adr, bus.mem_wdata, e_we, e_adr, e_dat);
      end
      if (reset) begin
        exp_q.delete();
        phase = 0;
      end else if (phase == 0) begin
        if (bus.v_req) begin
          for (int i = 0; i < LANES; i++)
            if (bus.v_mask[i]) exp_q.push_back({bus.v_base + AW'(i * STRIDE), bus.v_data[i*DW +: DW]});
          phase = (exp_q.size() != 0) ? 1 : 2;
        end
      end else if (phase == 1) begin
        if (!bus.s_we) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) phase = 2;
        end
      end else begin
        phase = 0;
      end
      next_cycle();
    end
    reset = 1'b0;
    drive_idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_full_vector();
    test_collision();
    test_sparse_empty();
    test_wrap();
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_write_sched.md
Name: dmem_write_sched

Overview:
Schedules all writes into the single-port data memory. Scalar stores from the single-cycle core pass through with zero latency and always win. A vector store (up to LANES words, per-lane mask) is latched in one cycle, then drained one lane per cycle into cycles where the core is not storing. Sits between the core's store outputs and the data memory in top.

Parameters:
LANES, 5, number of vector lanes (VecWriteData_0..4)
DW, 32, data word width
AW, 32, byte address width
STRIDE, 4, byte distance between consecutive lane addresses

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
s_we  in  1  scalar store enable (core MemWrite)
s_adr  in  AW  scalar store address (core DataAdr)
s_wdata  in  DW  scalar store data (core WriteData)
v_req  in  1  vector store request, sampled when v_ready=1
v_ready  out  1  scheduler can accept a vector store
v_base  in  AW  byte address of lane 0
v_mask  in  LANES  lane i written iff v_mask[i]=1
v_data  in  LANES*DW  lane i at bits [i*DW +: DW]
v_done  out  1  one-cycle pulse: vector store fully drained
busy  out  1  vector store pending
mem_we  out  1  data memory write enable
mem_adr  out  AW  data memory address
mem_wdata  out  DW  data memory write data

Behaviour:
- States: IDLE, DRAIN, DONE. Reset -> IDLE; data/mask/base registers cleared to 0.
- Reset outputs: v_ready=1, v_done=0, busy=0. mem_* follow s_* combinationally, so mem_we=s_we during reset.
- v_ready=1 only in IDLE; busy=1 in DRAIN.
- IDLE with v_req=1: latch v_base, v_mask, v_data.
  - Mask nonzero -> DRAIN.
  - Mask zero -> DONE; no memory write.
- v_req while v_ready=0 is ignored. The requester holds it.
- Lane select: cur = lowest set bit of the pending mask.
- DRAIN cycle with s_we=0:
  - mem_we=1, mem_adr = base + STRIDE*cur, mem_wdata = lane cur.
  - Clear pending bit cur at the edge.
  - If no bits remain -> DONE.
- DRAIN cycle with s_we=1: scalar store goes out; no lane retires; state holds.
- Address arithmetic is modulo 2^AW; wrap-around is legal.
- Scalar path, every state: s_we=1 -> mem_we=1, mem_adr=s_adr, mem_wdata=s_wdata in the same cycle (0 latency).
- mem_* outputs are combinational from registered state plus s_*. No other path drives mem_we.
- DONE: v_done=1 for exactly one cycle -> IDLE. v_ready=0 in DONE, so the earliest back-to-back accept is the cycle after DONE.
- Latency with no collisions: accept at edge N; lanes written in cycles N+1..N+k (k = popcount of mask); v_done in cycle N+k+1.
- Ordering: a scalar store overlapping a pending lane address is not detected. The core must not store to a vector's range while busy=1 (software rule, checked by assertion in the bench).
- Reset mid-DRAIN: pending lanes dropped, no v_done, IDLE next cycle.

Decomposition:
- Package dmem_sched_pkg holds:
  - state enum (IDLE, DRAIN, DONE)
  - LANES, DW, AW, STRIDE defaults
  - lane-slice helper function
- One sub-module, lane_pick: combinational lowest-set-bit encoder.
  - Input: LANES-bit mask.
  - Outputs: index and any-set flag.

Test Plan:
- Scalar pass-through: reset low, s_we=1, s_adr=100, s_wdata=7 -> same cycle mem_we=1, mem_adr=100, mem_wdata=7; v_ready=1.
- Full vector, no contention: base=0x200, mask=5'b11111, data=1..5 -> writes 0x200/1, 0x204/2, 0x208/3, 0x20C/4, 0x210/5 in cycles 1-5; v_done in cycle 6; v_ready back in cycle 7.
- Collision: same vector with s_we=1 (adr 96, data 9) in cycle 2 -> cycle 2 writes 96/9; lanes shift one cycle; last lane at 0x210 in cycle 6; v_done in cycle 7.
- Sparse/empty mask: mask=5'b10101 -> only 0x200, 0x208, 0x210 written in 3 cycles. mask=0 -> no mem_we; v_done one cycle after accept.
- Wrap: base=0xFFFFFFF8, mask=5'b00111 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-drain: reset after the second lane -> no further vector writes; v_done never pulses; v_ready=1 after reset deasserts. v_req held while busy is accepted only after DONE.
